// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam int DWORD_SHIFT = 3;
    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with a registered read; read returns pre-write contents.
module dmem_array #(
    parameter int SIZE       = 64,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [SIZE-1:0]       wdata,
    output logic [SIZE-1:0]       rdata
);

    logic [SIZE-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle doubleword load/store responder: captures one request, waits LATENCY
// cycles, accesses the internal RAM, then pulses done (and err for bad requests).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int SIZE       = 64,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic [SIZE-1:0] address,
    input  logic [SIZE-1:0] writeData,
    output logic [SIZE-1:0] readDataMem,
    output logic            stall,
    output logic            done,
    output logic            err
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_LO = DWORD_SHIFT;
    localparam int IDX_HI = DEPTH_LOG2 + DWORD_SHIFT - 1;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] idx_h;
    logic [SIZE-1:0]       wdata_h;
    logic                  write_h;
    logic                  err_h;

    logic                  req;
    logic                  bad_req;
    logic                  access;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_index;
    logic [SIZE-1:0]       ram_rdata;
    logic                  unused_addr_bits;

    assign req     = memRead | memWrite;
    assign bad_req = (address[DWORD_SHIFT-1:0] != '0) | (memRead & memWrite);
    assign access  = (state == WAIT) && (cnt == '0);
    assign stall   = req & ~done;

    // Upper address bits are deliberately ignored so addresses wrap over the array.
    assign unused_addr_bits = ^address[SIZE-1:IDX_HI+1];

    // The RAM sees the incoming index while idle so that even with LATENCY=1 the
    // registered read already holds the target word at the access edge.
    assign ram_index = (state == IDLE) ? address[IDX_HI:IDX_LO] : idx_h;
    assign ram_we    = access & write_h & ~err_h & ~reset;

    dmem_array #(
        .SIZE      (SIZE),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .index(ram_index),
        .wdata(wdata_h),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx_h       <= '0;
            wdata_h     <= '0;
            write_h     <= 1'b0;
            err_h       <= 1'b0;
            readDataMem <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx_h   <= address[IDX_HI:IDX_LO];
                        wdata_h <= writeData;
                        write_h <= memWrite;
                        err_h   <= bad_req;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (!err_h && !write_h) begin
                            readDataMem <= ram_rdata;
                        end
                        done  <= 1'b1;
                        err   <= err_h;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder at LATENCY 2, 1 and 15 against a
// word-array reference model.
module tb_dmem_responder;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    typedef struct {
        bit          rd;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        bit          exp_err;
        logic [63:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead     [NI];
    logic        memWrite    [NI];
    logic [63:0] address     [NI];
    logic [63:0] writeData   [NI];
    logic [63:0] readDataMem [NI];
    logic        stall       [NI];
    logic        done        [NI];
    logic        err         [NI];

    logic [63:0] mdl_mem [NI][256];
    logic [63:0] mdl_rd  [NI];

    int checks = 0;
    int errors = 0;

    vec_t vt [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .SIZE      (64),
            .DEPTH_LOG2(8),
            .LATENCY   (lat_of(g))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .memRead    (memRead[g]),
            .memWrite   (memWrite[g]),
            .address    (address[g]),
            .writeData  (writeData[g]),
            .readDataMem(readDataMem[g]),
            .stall      (stall[g]),
            .done       (done[g]),
            .err        (err[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a word array indexed by (byte address / 8) mod 256.
    task automatic model_step(input int k, input bit rd, input bit wr,
                              input logic [63:0] a, input logic [63:0] d,
                              output bit e, output logic [63:0] r);
        int idx;
        idx = int'((a / 64'd8) % 64'd256);
        e = ((a % 64'd8) != 64'd0) || (rd && wr);
        if (!e && wr) mdl_mem[k][idx] = d;
        if (!e && rd) mdl_rd[k] = mdl_mem[k][idx];
        r = mdl_rd[k];
    endtask

    // Entered just after a rising edge with the DUT idle; returns just after the
    // rising edge that ends the done cycle, with inputs released.
    task automatic run_req(input int k, input bit rd, input bit wr,
                           input logic [63:0] a, input logic [63:0] d,
                           input bit exp_err, input logic [63:0] exp_rd,
                           input bit drop_rd, input string nm);
        int L;
        bit exp_stall;
        L = lat_of(k);
        memRead[k]   = rd;
        memWrite[k]  = wr;
        address[k]   = a;
        writeData[k] = d;
        for (int c = 0; c <= L + 1; c++) begin
            @(negedge clk);
            if (c <= L) begin
                exp_stall = (drop_rd && c > 0) ? wr : 1'b1;
                chk($sformatf("%s[%0d] stall c%0d", nm, k, c), 64'(stall[k]), 64'(exp_stall));
                chk($sformatf("%s[%0d] done c%0d", nm, k, c), 64'(done[k]), 64'd0);
            end else begin
                chk($sformatf("%s[%0d] done", nm, k), 64'(done[k]), 64'd1);
                chk($sformatf("%s[%0d] err", nm, k), 64'(err[k]), 64'(exp_err));
                chk($sformatf("%s[%0d] stall", nm, k), 64'(stall[k]), 64'd0);
                chk($sformatf("%s[%0d] rdata", nm, k), readDataMem[k], exp_rd);
            end
            @(posedge clk);
            #1;
            if (drop_rd && c == 0) memRead[k] = 1'b0;
        end
        memRead[k]  = 1'b0;
        memWrite[k] = 1'b0;
    endtask

    task automatic model_req(input int k, input bit rd, input bit wr,
                             input logic [63:0] a, input logic [63:0] d,
                             input bit drop_rd, input string nm);
        bit e;
        logic [63:0] r;
        model_step(k, rd, wr, a, d, e, r);
        run_req(k, rd, wr, a, d, e, r, drop_rd, nm);
    endtask

    initial begin
        bit e;
        logic [63:0] r;
        logic [63:0] a;
        int op;

        vt[0] = '{1'b0, 1'b1, 64'h40,  64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
        vt[1] = '{1'b1, 1'b0, 64'h40,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[2] = '{1'b0, 1'b1, 64'h800, 64'h1,                 1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[3] = '{1'b1, 1'b0, 64'h0,   64'h0,                 1'b0, 64'h1};
        vt[4] = '{1'b0, 1'b1, 64'h44,  64'h5,                 1'b1, 64'h1};
        vt[5] = '{1'b1, 1'b0, 64'h40,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[6] = '{1'b1, 1'b1, 64'h40,  64'h77,                1'b1, 64'hDEADBEEF_CAFEF00D};
        vt[7] = '{1'b1, 1'b0, 64'h40,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            memRead[k]   = 1'b0;
            memWrite[k]  = 1'b0;
            address[k]   = '0;
            writeData[k] = '0;
            mdl_rd[k]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset[%0d] rdata", k), readDataMem[k], 64'h0);
            chk($sformatf("reset[%0d] done", k), 64'(done[k]), 64'd0);
            chk($sformatf("reset[%0d] err", k), 64'(err[k]), 64'd0);
            chk($sformatf("reset[%0d] stall", k), 64'(stall[k]), 64'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            model_step(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, e, r);
            run_req(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data,
                    vt[i].exp_err, vt[i].exp_rd, 1'b0, $sformatf("vec%0d", i));
        end

        // Load with memRead dropped after cycle 0 still completes with data.
        model_step(0, 1'b1, 1'b0, 64'h40, 64'h0, e, r);
        run_req(0, 1'b1, 1'b0, 64'h40, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 1'b1, "drop");

        // Store interrupted by a 3-cycle reset must not reach the RAM.
        model_req(0, 1'b0, 1'b1, 64'h8, 64'h1111, 1'b0, "pre");
        memWrite[0]  = 1'b1;
        address[0]   = 64'h8;
        writeData[0] = 64'h99;
        @(posedge clk);
        #1;
        memWrite[0] = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < NI; k++) mdl_rd[k] = '0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("midrst[%0d] rdata", k), readDataMem[k], 64'h0);
            chk($sformatf("midrst[%0d] done", k), 64'(done[k]), 64'd0);
        end
        chk("midrst err", 64'(err[0]), 64'd0);
        chk("midrst stall", 64'(stall[0]), 64'd0);
        @(posedge clk);
        #1;
        model_req(0, 1'b1, 1'b0, 64'h8, 64'h0, 1'b0, "postrst");

        // Randomized back-to-back traffic on every latency variant.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) begin
                a = {$urandom, $urandom};
                a[10:3] = 8'(i);
                a[2:0] = 3'd0;
                model_req(k, 1'b0, 1'b1, a, {$urandom, $urandom}, 1'b0, "fill");
            end
            for (int i = 0; i < 14; i++) begin
                a = {$urandom, $urandom};
                a[10:3] = 8'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
                else a[2:0] = 3'd0;
                op = $urandom_range(0, 7);
                model_req(k, (op <= 3), (op == 0 || op >= 4), a, {$urandom, $urandom},
                          1'b0, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory side of the datapath's load/store interface (memRead, memWrite, ALU address, register writeData, readDataMem). It accepts one doubleword request at a time, serves it from an internal synchronous RAM after a fixed latency, and drives a combinational stall so the single-cycle core can hold PCen low until the access completes. It sits between the datapath's data_MEM port and the future memory hierarchy.

## Interface
- SIZE, 64, data and address width in bits
- DEPTH_LOG2, 8, log2 of doubleword entries (256 × 64 bit)
- LATENCY, 2, wait cycles before access; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- memRead  in  1  load request
- memWrite  in  1  store request
- address  in  SIZE  byte address, doubleword aligned
- writeData  in  SIZE  store data
- readDataMem  out  SIZE  registered load data
- stall  out  1  combinational; high while a request is pending and not yet done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if memRead|memWrite, capture address, writeData, op into holding registers, load cnt=LATENCY-1, go to WAIT.
- WAIT: if cnt==0, perform access at this edge and go to DONE; else cnt decrements.
- Access: index = captured address[DEPTH_LOG2+2:3]; upper address bits ignored, so addresses wrap modulo 2^(DEPTH_LOG2+3).
  - Store: RAM[index] ← captured writeData.
  - Load: readDataMem ← RAM[index].
- DONE: done=1 for one cycle, then unconditional return to IDLE. A request visible in DONE is not accepted; it is accepted in the following IDLE cycle.
- Errors are checked at capture; at the access edge there is no RAM write and readDataMem is unchanged; err=1 in DONE. Error cases:
  - address[2:0]≠0 (misaligned)
  - memRead and memWrite both high
- Inputs are captured once at accept. Changes or deassertion during WAIT are ignored and the captured request completes.
- stall = (memRead|memWrite) & ~done, in every state.
- Reset values:
  - state=IDLE, cnt=0
  - readDataMem=0, done=0, err=0
  - holding registers 0
  - RAM contents not reset
- Reset mid-operation: return to IDLE next cycle. No RAM write occurs unless the access edge was already reached before reset was asserted.

## Timing
- Request first visible in cycle 0, while in IDLE.
- Access edge is the end of cycle LATENCY.
- done, err and valid readDataMem are present in cycle LATENCY+1.
- stall is high in cycles 0..LATENCY and low in cycle LATENCY+1, so the core advances at the end of that cycle.
- Back-to-back requests: the next request is first seen in cycle LATENCY+2, giving a throughput of one access per LATENCY+2 cycles.
- readDataMem holds its value until the next successful load completes.
- Read-after-write to the same index returns the new data, because the accesses are sequential.

## Structure
- Package dmem_pkg holds:
  - state enum (IDLE, WAIT, DONE)
  - DWORD_SHIFT=3
  - maximum LATENCY constant
- Sub-module dmem_array is a single-port synchronous RAM (clk, we, index, wdata, rdata) with a registered read.
- dmem_responder holds the FSM, counter, holding registers and error checks.
- Counter width is $clog2(LATENCY+1).

## Test plan
- Reset, then idle: readDataMem=0, done=0, err=0, stall=0. Hold reset for 3 cycles during a pending WAIT: no write, state is IDLE afterwards.
- Store 0xDEADBEEF_CAFEF00D to 0x40 with LATENCY=2: stall high in cycles 0–2, done in cycle 3. Then load 0x40: readDataMem=0xDEADBEEF_CAFEF00D in cycle 3 of the load.
- Wrap: store 0x1 to 0x800 (index 0 when DEPTH_LOG2=8), then load 0x0: returns 0x1.
- Misaligned store to 0x44 with data 0x5: err=1 and done=1 in cycle 3; a load from 0x40 still returns the old value.
- Both memRead and memWrite high: err=1, no write, readDataMem unchanged. Also deassert memRead in cycle 1 of a load from 0x40: the load still completes with the correct data in cycle 3.
- Sweep LATENCY=1 and LATENCY=15: done occurs exactly in cycle LATENCY+1; back-to-back requests spaced every LATENCY+2 cycles.
